// File: rtl/proc_trace_pkg.sv
// rtl/proc_trace_pkg.sv - shared types for the processor execution-trace monitor
package proc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } trace_st_t;

  localparam int TRACE_PC_W    = 64;
  localparam int TRACE_INSTR_W = 32;

  // Default entry layout for a 64-bit PC core; the top rebuilds it for other DATA_W.
  typedef struct packed {
    logic [TRACE_PC_W-1:0]    pc;
    logic [TRACE_INSTR_W-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_monitor_if.sv
// rtl/proc_trace_monitor_if.sv - snoop bus from the processing unit to the trace monitor
interface proc_trace_monitor_if #(
  parameter int DATA_W  = 64,
  parameter int STATE_W = 5
);
  logic [DATA_W-1:0]  PCIn;
  logic [31:0]        Instr31_0;
  logic [STATE_W-1:0] state;
  logic               DMemWrite;

  modport master (output PCIn, Instr31_0, state, DMemWrite);
  modport slave  (input  PCIn, Instr31_0, state, DMemWrite);
endinterface

// File: rtl/trace_ring_buffer.sv
// rtl/trace_ring_buffer.sv - circular trace store with pop port, wrap/drop on full
module trace_ring_buffer
  import proc_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t,
  parameter bit  WRAP    = 1'b1
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   i_push,
  input  entry_t                 i_push_data,
  input  logic                   i_pop,
  output logic                   o_rd_valid,
  output entry_t                 o_rd_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_rd_valid;
  entry_t             r_rd_data;
  logic               r_overflow;

  logic w_full, w_empty, w_pop, w_evict, w_drop, w_write;

  // A pop in the same cycle frees a slot, so a full buffer never evicts or drops then.
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_empty = (r_count == '0);
    w_pop   = i_pop && !w_empty;
    w_evict = i_push && !w_pop && w_full && WRAP;
    w_drop  = i_push && !w_pop && w_full && !WRAP;
    w_write = i_push && !w_drop;
  end

  always_ff @(posedge clk) begin
    if (Reset_n && w_write) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_evict) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_overflow <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
      if (w_write && !w_pop && !w_evict) r_count <= r_count + 1'b1;
      else if (w_pop && !w_write)        r_count <= r_count - 1'b1;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/proc_trace_monitor.sv
// rtl/proc_trace_monitor.sv - trace monitor top: retire detect, trigger, watchdog, counters
module proc_trace_monitor
  import proc_trace_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int STATE_W     = 5,
  parameter int FETCH_STATE = 0,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 32,
  parameter bit WRAP        = 1'b1
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  input  logic                   en,
  proc_trace_monitor_if.slave    core,
  input  logic                   trig_en,
  input  logic [DATA_W-1:0]      trig_pc,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [31:0]            rd_instr,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       retired,
  output logic [CNT_W-1:0]       stores,
  output logic                   hang,
  output logic                   overflow,
  output logic                   frozen
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int PT_W = (POST_TRIG < 2) ? 1 : $clog2(POST_TRIG + 1);

  typedef struct packed {
    logic [DATA_W-1:0]        pc;
    logic [TRACE_INSTR_W-1:0] instr;
  } entry_t;

  trace_st_t          r_st;
  logic [STATE_W-1:0] r_prev_state;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_trig_hit;
  logic [PT_W-1:0]    r_post_cnt;
  logic [CNT_W-1:0]   r_retired;
  logic [CNT_W-1:0]   r_stores;
  logic               r_hang;

  logic   w_run, w_retire, w_push, w_match, w_post_done, w_hang_rise, w_freeze;
  entry_t w_push_data;
  entry_t w_rd_data;

  always_comb begin
    w_run    = (r_st == RUN);
    w_retire = (core.state == STATE_W'(FETCH_STATE)) &&
               (r_prev_state != STATE_W'(FETCH_STATE));
    w_push   = w_run && w_retire;
    w_match  = w_push && !r_trig_hit && trig_en && (core.PCIn == trig_pc);
    // The match push itself is not counted toward the post-trigger window.
    if (POST_TRIG == 0) w_post_done = w_match;
    else w_post_done = w_push && r_trig_hit &&
                       (r_post_cnt == PT_W'(POST_TRIG > 0 ? POST_TRIG - 1 : 0));
    w_hang_rise = w_run && !w_retire && !r_hang && (r_wd_cnt == WD_W'(TIMEOUT - 1));
    w_freeze    = w_post_done || w_hang_rise;
    w_push_data = {core.PCIn, core.Instr31_0};
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_st         <= IDLE;
      r_prev_state <= '1;
      r_wd_cnt     <= '0;
      r_trig_hit   <= 1'b0;
      r_post_cnt   <= '0;
      r_retired    <= '0;
      r_stores     <= '0;
      r_hang       <= 1'b0;
    end else begin
      r_prev_state <= core.state;
      if (!en) r_st <= IDLE;
      else begin
        case (r_st)
          IDLE:    r_st <= RUN;
          RUN:     if (w_freeze) r_st <= FROZEN;
          FROZEN:  r_st <= FROZEN;
          default: r_st <= IDLE;
        endcase
      end
      if (!en || w_freeze) r_trig_hit <= 1'b0;
      else if (w_match) begin
        r_trig_hit <= 1'b1;
        r_post_cnt <= '0;
      end else if (w_push && r_trig_hit) r_post_cnt <= r_post_cnt + 1'b1;
      if (w_push && r_retired != '1) r_retired <= r_retired + 1'b1;
      if (w_run && core.DMemWrite && r_stores != '1) r_stores <= r_stores + 1'b1;
      if (w_run) begin
        if (w_retire) r_wd_cnt <= '0;
        else if (r_wd_cnt != WD_W'(TIMEOUT)) r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_hang_rise) r_hang <= 1'b1;
    end
  end

  trace_ring_buffer #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .WRAP    (WRAP)
  ) u_ring (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (rd_req),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (w_rd_data),
    .o_count     (count),
    .o_overflow  (overflow)
  );

  assign rd_pc    = w_rd_data.pc;
  assign rd_instr = w_rd_data.instr;
  assign retired  = r_retired;
  assign stores   = r_stores;
  assign hang     = r_hang;
  assign frozen   = (r_st == FROZEN);
endmodule
